// File: rtl/fpu_mult_pkg.sv
// Shared definitions for the floating-point multiply path.
package fpu_mult_pkg;

    localparam int unsigned MANT_W  = 24;
    localparam int unsigned PROD_W  = 48;
    localparam int unsigned SHIFT_W = 10;

    // Normalisation shift is (leading-one position - SHIFT_BIAS).
    localparam int unsigned SHIFT_BIAS = 46;
    // Shift reported when the leading one sits below the hidden-bit position.
    localparam logic [SHIFT_W-1:0] SHIFT_UFLOW = 10'h3E8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_NORM,
        ST_DONE
    } mult_state_t;

endpackage

// File: rtl/lead_one_det.sv
// Combinational priority encoder: position of the most significant set bit.
module lead_one_det
    import fpu_mult_pkg::*;
#(
    parameter int unsigned W     = PROD_W,
    parameter int unsigned POS_W = $clog2(W)
) (
    input  logic [W-1:0]     vec,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        pos  = '0;
        zero = ~|vec;
        for (int unsigned i = 0; i < W; i++) begin
            if (vec[i]) begin
                pos = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/mant_mult_seq.sv
// Iterative shift-add mantissa multiplier with normalisation-shift output.
module mant_mult_seq
    import fpu_mult_pkg::*;
#(
    parameter int unsigned MANT_W  = 24,
    parameter int unsigned SHIFT_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_W-1:0]     mant_a,
    input  logic [MANT_W-1:0]     mant_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*MANT_W-1:0]   mant_product,
    output logic [SHIFT_W-1:0]    shift,
    output logic                  prod_zero,
    output logic                  underflow
);

    localparam int unsigned PW    = 2 * MANT_W;
    localparam int unsigned CNT_W = $clog2(MANT_W);
    localparam int unsigned POS_W = $clog2(PW);

    localparam logic [SHIFT_W-1:0] BIAS  = SHIFT_W'(PW - 2);
    localparam logic [SHIFT_W-1:0] UFLOW = SHIFT_W'(0) - SHIFT_W'(MANT_W);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(MANT_W - 1);
    localparam logic [POS_W-1:0]   HID   = POS_W'(MANT_W - 1);

    mult_state_t          state;
    mult_state_t          next_state;
    logic [MANT_W-1:0]    a_q;
    logic [PW-1:0]        acc;
    logic [CNT_W-1:0]     step;
    logic [MANT_W:0]      sum;
    logic [POS_W-1:0]     lead_pos;
    logic                 lead_zero;

    lead_one_det #(
        .W     (PW),
        .POS_W (POS_W)
    ) u_lod (
        .vec  (acc),
        .pos  (lead_pos),
        .zero (lead_zero)
    );

    // Upper accumulator half plus multiplicand, carry kept in the top bit.
    always_comb begin
        sum = {1'b0, acc[PW-1:MANT_W]} + {1'b0, a_q};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = ST_MUL;
                end
            end
            ST_MUL: begin
                if (step == LAST) begin
                    next_state = ST_NORM;
                end
            end
            ST_NORM: begin
                next_state = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Operand/accumulator datapath; the multiplier occupies the low half of
    // acc and is consumed one bit per step as the partial sum shifts in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            acc  <= '0;
            step <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q  <= mant_a;
                        acc  <= {{MANT_W{1'b0}}, mant_b};
                        step <= '0;
                    end
                end
                ST_MUL: begin
                    if (acc[0]) begin
                        acc <= {sum, acc[MANT_W-1:1]};
                    end else begin
                        acc <= {1'b0, acc[PW-1:1]};
                    end
                    step <= step + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers, loaded only on the normalisation edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_product <= '0;
            shift        <= '0;
            prod_zero    <= 1'b0;
            underflow    <= 1'b0;
        end else if (state == ST_NORM) begin
            mant_product <= acc;
            if (lead_zero) begin
                shift     <= '0;
                prod_zero <= 1'b1;
                underflow <= 1'b0;
            end else if (lead_pos < HID) begin
                shift     <= UFLOW;
                prod_zero <= 1'b0;
                underflow <= 1'b1;
            end else begin
                shift     <= SHIFT_W'(lead_pos) - BIAS;
                prod_zero <= 1'b0;
                underflow <= 1'b0;
            end
        end
    end

endmodule
